sobel_edge_top: RTL and testbench

//  Self-contained Sobel edge-detection engine: scans an internal RGB image memory, converts each

---
 rtl/sobel_pkg.sv | 31 +++
 rtl/sobel_kernel.sv | 28 ++
 rtl/sobel_edge_top.sv | 114 +++++++++++
 tb/tb_sobel_edge_top.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel edge engine: FSM state encodings,
// 3x3 kernel coefficients (taps in raster order p0..p8) and the RGB to gray helper.
package sobel_pkg;

    typedef logic [1:0] state_t;

    localparam state_t FETCH = 2'd0;
    localparam state_t CALC  = 2'd1;
    localparam state_t WRITE = 2'd2;
    localparam state_t DONE  = 2'd3;

    localparam logic signed [2:0] gx_coef [9] = '{
        -3'sd1, 3'sd0, 3'sd1,
        -3'sd2, 3'sd0, 3'sd2,
        -3'sd1, 3'sd0, 3'sd1
    };

    localparam logic signed [2:0] gy_coef [9] = '{
        -3'sd1, -3'sd2, -3'sd1,
         3'sd0,  3'sd0,  3'sd0,
         3'sd1,  3'sd2,  3'sd1
    };

    // Green counts twice; the 10-bit sum cannot overflow for 8-bit channels.
    function automatic logic [7:0] rgb2gray(input logic [23:0] px);
        logic [9:0] sum;
        sum = {2'b00, px[23:16]} + {1'b0, px[15:8], 1'b0} + {2'b00, px[7:0]};
        return 8'(sum >> 2);
    endfunction

endpackage

// File: rtl/sobel_kernel.sv
// Combinational Sobel operator: nine gray taps in, |Gx|+|Gy| saturated to 8 bits out.
module sobel_kernel
    import sobel_pkg::*;
(
    input  logic [8:0][7:0] taps,
    output logic [7:0]      mag
);

    logic signed [10:0] gx;
    logic signed [10:0] gy;
    logic signed [10:0] ax;
    logic signed [10:0] ay;
    logic [11:0]        sum;

    always_comb begin
        gx = '0;
        gy = '0;
        for (int i = 0; i < 9; i++) begin
            gx = gx + 11'(gx_coef[i]) * $signed({3'b000, taps[i]});
            gy = gy + 11'(gy_coef[i]) * $signed({3'b000, taps[i]});
        end
        ax  = gx[10] ? -gx : gx;
        ay  = gy[10] ? -gy : gy;
        sum = {1'b0, ax} + {1'b0, ay};
        mag = (sum > 12'd255) ? 8'hff : sum[7:0];
    end

endmodule

// File: rtl/sobel_edge_top.sv
// Sobel edge engine: walks every 3x3 window of the input image memory and
// stores the saturated gradient magnitude of each window in the output memory.
module sobel_edge_top
    import sobel_pkg::*;
#(
    parameter int data_size    = 24,
    parameter int img_width    = 225,
    parameter int window_count = 49729
) (
    input  logic clk,
    input  logic reset,
    output logic done
);

    localparam int pix_count = img_width * img_width;
    localparam int aw        = $clog2(pix_count);
    localparam int kw        = (window_count > 1) ? $clog2(window_count) : 1;

    logic [data_size-1:0] in_mem  [pix_count] = '{default: '0};
    logic [data_size-1:0] out_mem [window_count];

    // Declaration values double as power-up state so a run starts without reset.
    state_t          state   = FETCH;
    logic [kw-1:0]   k       = '0;
    logic [3:0]      tap     = '0;
    logic [aw-1:0]   base    = '0;
    logic [aw-1:0]   col     = '0;
    logic [7:0]      rd_gray = '0;
    logic [7:0][7:0] tap_reg = '0;
    logic [7:0]      mag     = '0;

    logic [aw-1:0]   offset;
    logic [aw-1:0]   rd_addr;
    logic [7:0]      kernel_mag;

    always_comb begin
        case (tap)
            4'd0:    offset = '0;
            4'd1:    offset = aw'(1);
            4'd2:    offset = aw'(2);
            4'd3:    offset = aw'(img_width);
            4'd4:    offset = aw'(img_width + 1);
            4'd5:    offset = aw'(img_width + 2);
            4'd6:    offset = aw'(2 * img_width);
            4'd7:    offset = aw'(2 * img_width + 1);
            4'd8:    offset = aw'(2 * img_width + 2);
            default: offset = '0;
        endcase
    end

    assign rd_addr = base + offset;

    // rd_gray lags the address by one cycle, so it holds p8 during CALC.
    sobel_kernel u_kernel (
        .taps ({rd_gray, tap_reg}),
        .mag  (kernel_mag)
    );

    always_ff @(posedge clk) begin
        rd_gray <= rgb2gray(in_mem[rd_addr]);
        if (state == FETCH && tap != 4'd0) begin
            tap_reg <= {rd_gray, tap_reg[7:1]};
        end
        if (state == CALC) begin
            mag <= kernel_mag;
        end
        if (!reset && state == WRITE) begin
            out_mem[k] <= {mag, mag, mag};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            k     <= '0;
            tap   <= '0;
            base  <= '0;
            col   <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (tap == 4'd8) begin
                        tap   <= '0;
                        state <= CALC;
                    end else begin
                        tap <= tap + 4'd1;
                    end
                end
                CALC: state <= WRITE;
                WRITE: begin
                    if (k == kw'(window_count - 1)) begin
                        state <= DONE;
                    end else begin
                        k     <= k + 1'b1;
                        state <= FETCH;
                        // Leaving the last column skips the two border pixels of the row.
                        if (col == aw'(img_width - 3)) begin
                            col  <= '0;
                            base <= base + aw'(3);
                        end else begin
                            col  <= col + 1'b1;
                            base <= base + 1'b1;
                        end
                    end
                end
                DONE:    state <= DONE;
                default: state <= FETCH;
            endcase
        end
    end

    assign done = (state == DONE);

endmodule

// File: tb/tb_sobel_edge_top.sv
// Directed bench for sobel_edge_top on a 4x4 image: loads pixels into the input memory,
// times done against the 11-cycle-per-window schedule and checks every output word.
module tb_sobel_edge_top;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic done;

    int checks = 0;
    int errors = 0;
    int cycles;
    int drops;
    logic [23:0] exp_out [4];

    sobel_edge_top #(
        .data_size    (24),
        .img_width    (4),
        .window_count (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input int pattern);
        logic [23:0] px;
        for (int i = 0; i < 16; i++) begin
            case (pattern)
                0:       px = 24'h808080;
                1:       px = ((i % 4) >= 2) ? 24'h010101 : 24'h000000;
                2:       px = ((i % 4) >= 2) ? 24'hffffff : 24'h000000;
                default: px = (i == 0) ? 24'h001400 : ((i == 15) ? 24'h140000 : 24'h000000);
            endcase
            dut.in_mem[i] = px;
        end
    endtask

    task automatic wait_done(output int n_cycles);
        n_cycles = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                n_cycles = n;
                break;
            end
        end
    endtask

    task automatic check_all_outputs(input string tag);
        for (int j = 0; j < 4; j++) begin
            check_output($sformatf("%s_out%0d", tag, j), 32'(dut.out_mem[j]), 32'(exp_out[j]));
        end
    endtask

    initial begin
        $display("[TB] start");

        // Power-up run with no reset at all.
        #1;
        apply_stimulus(1);
        check_output("pwr_done_init", 32'(done), 32'd0);
        wait_done(cycles);
        check_output("pwr_latency", 32'(cycles), 32'd44);
        exp_out = '{24'h040404, 24'h040404, 24'h040404, 24'h040404};
        check_all_outputs("pwr");
        drops = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (done !== 1'b1) drops++;
        end
        check_output("done_hold", 32'(drops), 32'd0);

        // Reset from DONE, uniform image gives zero gradient everywhere.
        apply_stimulus(0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_output("done_after_reset", 32'(done), 32'd0);
        reset = 1'b0;
        wait_done(cycles);
        check_output("uniform_latency", 32'(cycles), 32'd44);
        exp_out = '{24'h000000, 24'h000000, 24'h000000, 24'h000000};
        check_all_outputs("uniform");

        // Saturating edge, with a reset pulse that never spans a posedge.
        apply_stimulus(2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        wait_done(cycles);
        check_output("glitch_latency", 32'(cycles + 10), 32'd44);
        exp_out = '{24'hffffff, 24'hffffff, 24'hffffff, 24'hffffff};
        check_all_outputs("sat");

        // Isolated corner pixels: negative gradients, green weighting and window order.
        apply_stimulus(3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_done(cycles);
        check_output("mixed_latency", 32'(cycles), 32'd44);
        exp_out = '{24'h141414, 24'h000000, 24'h000000, 24'h0a0a0a};
        check_all_outputs("mixed");

        // Reset mid-run restarts from window 0.
        apply_stimulus(1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check_output("midrun_done", 32'(done), 32'd0);
        reset = 1'b0;
        wait_done(cycles);
        check_output("midrun_latency", 32'(cycles), 32'd44);
        exp_out = '{24'h040404, 24'h040404, 24'h040404, 24'h040404};
        check_all_outputs("midrun");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
